// File: rtl/fp_pkg.sv
// Shared FP definitions: format defaults, rounding-mode encodings and the
// normalise/round FSM state type.
package fp_pkg;

    localparam int unsigned FPWID_DEF = 32;
    localparam int unsigned EMSB_DEF  = 7;
    localparam int unsigned FMSB_DEF  = 22;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StDenorm,
        StRound
    } state_e;

    // On exponent overflow: true when the mode rounds away to infinity,
    // false when it saturates at the largest finite value.
    function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
        return (rm == RM_RNE) || (rm == RM_RMM) ||
               ((rm == RM_RUP) && !sign) || ((rm == RM_RDN) && sign);
    endfunction

endpackage

// File: rtl/fpdiv_rnd.sv
// Combinational mantissa rounder: applies the rounding-mode increment from
// guard/sticky and reports carry-out and inexact.
module fpdiv_rnd
    import fp_pkg::*;
#(
    parameter int unsigned MW = FMSB_DEF + 2
) (
    input  logic [MW-1:0] man_i,
    input  logic          g_i,
    input  logic          s_i,
    input  logic          sign_i,
    input  logic [2:0]    rm_i,
    output logic [MW-1:0] man_o,
    output logic          carry_o,
    output logic          inexact_o
);

    logic        inc;
    logic [MW:0] sum;

    always_comb begin
        inc = 1'b0;
        case (rm_i)
            RM_RNE:  inc = g_i & (s_i | man_i[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_i & (g_i | s_i);
            RM_RUP:  inc = ~sign_i & (g_i | s_i);
            RM_RMM:  inc = g_i;
            default: inc = 1'b0;
        endcase
        sum       = {1'b0, man_i} + {{MW{1'b0}}, inc};
        carry_o   = sum[MW];
        // All-ones plus one wraps to zero; the value is 1.0 at the next exponent.
        man_o     = carry_o ? {1'b1, {(MW - 1){1'b0}}} : sum[MW-1:0];
        inexact_o = g_i | s_i;
    end

endmodule

// File: rtl/fpdivr8_normround.sv
// Normalise/round stage after the radix-8 divider: normalises the quotient,
// right-shifts denormals one bit per cycle, rounds and packs the result.
module fpdivr8_normround
    import fp_pkg::*;
#(
    parameter int unsigned FPWID = FPWID_DEF,
    parameter int unsigned EMSB  = EMSB_DEF,
    parameter int unsigned FMSB  = FMSB_DEF,
    localparam int unsigned QW   = FMSB + 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_i,
    input  logic                    sign_i,
    input  logic signed [EMSB+2:0]  exp_i,
    input  logic [2:0]              rm_i,
    input  logic [QW-1:0]           q_i,
    input  logic [QW-1:0]           r_i,
    output logic [FPWID-1:0]        o_o,
    output logic                    inexact_o,
    output logic                    overflow_o,
    output logic                    underflow_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned EW   = EMSB + 3;
    localparam int unsigned MW   = FMSB + 2;
    localparam int unsigned DCAP = FMSB + 3;
    localparam int unsigned DCW  = $clog2(DCAP + 1);
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << (EMSB + 1)) - 1);

    state_e                 state_q;
    logic                   sign_q;
    logic [2:0]             rm_q;
    logic signed [EW-1:0]   exp_q;
    logic [QW-1:0]          mant_q;
    logic                   sticky_q;
    logic                   zero_q;
    logic                   denorm_q;
    logic [DCW-1:0]         dcnt_q;
    logic                   rstage_q;
    logic [MW-1:0]          rman_q;
    logic signed [EW-1:0]   rexp_q;
    logic                   rinx_q;
    logic [FPWID-1:0]       o_q;
    logic                   inexact_q;
    logic                   overflow_q;
    logic                   underflow_q;
    logic                   done_q;

    logic                   norm_shift;
    logic [QW-1:0]          norm_mant;
    logic signed [EW-1:0]   norm_exp;
    logic                   norm_tiny;

    assign norm_shift = ~mant_q[QW-1];
    assign norm_mant  = norm_shift ? {mant_q[QW-2:0], 1'b0} : mant_q;
    assign norm_exp   = exp_q - {{(EW - 1){1'b0}}, norm_shift};
    assign norm_tiny  = norm_exp[EW-1] || (norm_exp == '0);

    logic [MW-1:0] rnd_man;
    logic          rnd_carry;
    logic          rnd_inexact;
    logic          rnd_s;

    assign rnd_s = (|mant_q[1:0]) | sticky_q;

    fpdiv_rnd #(
        .MW (MW)
    ) u_rnd (
        .man_i     (mant_q[QW-1:3]),
        .g_i       (mant_q[2]),
        .s_i       (rnd_s),
        .sign_i    (sign_q),
        .rm_i      (rm_q),
        .man_o     (rnd_man),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    // Packing of the registered rounding result (second ROUND cycle).
    logic [EMSB:0]    efield;
    logic             ovf_hit;
    logic [FPWID-1:0] res_o;
    logic             res_inx;
    logic             res_ovf;
    logic             res_unf;

    always_comb begin
        // Integer bit clear means the value is still subnormal: field 0.
        efield  = rman_q[MW-1] ? rexp_q[EMSB:0] : '0;
        ovf_hit = !zero_q && (rexp_q >= EXP_MAX);
        res_o   = {sign_q, efield, rman_q[FMSB:0]};
        res_inx = rinx_q;
        res_ovf = 1'b0;
        res_unf = (denorm_q || (efield == '0)) && rinx_q;
        if (zero_q) begin
            res_o   = {sign_q, {(FPWID - 1){1'b0}}};
            res_inx = 1'b0;
            res_unf = 1'b0;
        end else if (ovf_hit) begin
            res_ovf = 1'b1;
            res_inx = 1'b1;
            res_unf = 1'b0;
            res_o   = ovf_to_inf(rm_q, sign_q) ?
                      {sign_q, {(EMSB + 1){1'b1}}, {(FMSB + 1){1'b0}}} :
                      {sign_q, {EMSB{1'b1}}, 1'b0, {(FMSB + 1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sign_q      <= 1'b0;
            rm_q        <= RM_RNE;
            exp_q       <= '0;
            mant_q      <= '0;
            sticky_q    <= 1'b0;
            zero_q      <= 1'b0;
            denorm_q    <= 1'b0;
            dcnt_q      <= '0;
            rstage_q    <= 1'b0;
            rman_q      <= '0;
            rexp_q      <= '0;
            rinx_q      <= 1'b0;
            o_q         <= '0;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The done cycle still counts as busy, so ld there is dropped.
                    if (ld_i && !done_q) begin
                        sign_q   <= sign_i;
                        exp_q    <= exp_i;
                        rm_q     <= rm_i;
                        mant_q   <= q_i;
                        sticky_q <= |r_i;
                        zero_q   <= 1'b0;
                        denorm_q <= 1'b0;
                        dcnt_q   <= '0;
                        rstage_q <= 1'b0;
                        state_q  <= StNorm;
                    end
                end
                StNorm: begin
                    if (mant_q == '0) begin
                        zero_q  <= 1'b1;
                        state_q <= StRound;
                    end else begin
                        mant_q <= norm_mant;
                        exp_q  <= norm_exp;
                        if (norm_tiny) begin
                            denorm_q <= 1'b1;
                            state_q  <= StDenorm;
                        end else begin
                            state_q <= StRound;
                        end
                    end
                end
                StDenorm: begin
                    dcnt_q <= dcnt_q + 1'b1;
                    exp_q  <= exp_q + EXP_ONE;
                    if (exp_q == '0) begin
                        mant_q   <= {1'b0, mant_q[QW-1:1]};
                        sticky_q <= sticky_q | mant_q[0];
                        state_q  <= StRound;
                    end else if (dcnt_q == DCW'(DCAP - 1)) begin
                        // Every significant bit is below guard by now.
                        mant_q   <= '0;
                        sticky_q <= sticky_q | (|mant_q);
                        exp_q    <= EXP_ONE;
                        state_q  <= StRound;
                    end else begin
                        mant_q   <= {1'b0, mant_q[QW-1:1]};
                        sticky_q <= sticky_q | mant_q[0];
                    end
                end
                StRound: begin
                    if (!rstage_q) begin
                        rstage_q <= 1'b1;
                        rman_q   <= rnd_man;
                        rexp_q   <= exp_q + {{(EW - 1){1'b0}}, rnd_carry};
                        rinx_q   <= rnd_inexact;
                    end else begin
                        rstage_q    <= 1'b0;
                        o_q         <= res_o;
                        inexact_q   <= res_inx;
                        overflow_q  <= res_ovf;
                        underflow_q <= res_unf;
                        done_q      <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_o         = o_q;
    assign inexact_o   = inexact_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_fpdivr8_normround.sv
// Scoreboard bench for fpdivr8_normround: directed vectors push expected results,
// a monitor pops and compares on every done pulse.
module tb_fpdivr8_normround;

    logic               clk = 1'b0;
    logic               rst;
    logic               ld_s;
    logic               sign_s;
    logic signed [9:0]  exp_s;
    logic [2:0]         rm_s;
    logic [26:0]        q_s;
    logic [26:0]        r_s;
    logic [31:0]        o_o;
    logic               inexact_o;
    logic               overflow_o;
    logic               underflow_o;
    logic               busy_o;
    logic               done_o;

    fpdivr8_normround dut (
        .clk         (clk),
        .rst         (rst),
        .ld_i        (ld_s),
        .sign_i      (sign_s),
        .exp_i       (exp_s),
        .rm_i        (rm_s),
        .q_i         (q_s),
        .r_i         (r_s),
        .o_o         (o_o),
        .inexact_o   (inexact_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] o;
        logic        inx;
        logic        ovf;
        logic        unf;
        int          issue;
        int          lmin;
        int          lmax;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   cyc = 0;
    int   done_cnt = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got o=%h, expected no done", o_o);
            end else begin
                int lat;
                mx = sb.pop_front();
                lat = cyc - mx.issue;
                chk({mx.name, ".o"}, o_o, mx.o);
                chk({mx.name, ".flags(ix,ov,uf)"}, {29'd0, inexact_o, overflow_o, underflow_o},
                    {29'd0, mx.inx, mx.ovf, mx.unf});
                total_cnt++;
                if (lat >= mx.lmin && lat <= mx.lmax) pass_cnt++;
                else $display("FAIL %s.latency: got %0d, expected %0d..%0d", mx.name, lat,
                              mx.lmin, mx.lmax);
            end
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done_o && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) begin
            total_cnt++;
            $display("FAIL %s.timeout: got no done, expected done within 80 cycles", nm);
        end
    endtask

    task automatic drive(input logic sgn, input int e, input logic [2:0] rm,
                         input logic [26:0] qv, input logic rv);
        sign_s = sgn;
        exp_s  = 10'(e);
        rm_s   = rm;
        q_s    = qv;
        r_s    = {26'd0, rv};
        ld_s   = 1'b1;
    endtask

    task automatic send(input string nm, input logic sgn, input int e, input logic [2:0] rm,
                        input logic [26:0] qv, input logic rv, input logic [31:0] eo,
                        input logic ei, input logic eov, input logic eu,
                        input int lmin, input int lmax);
        exp_t x;
        x.name = nm; x.o = eo; x.inx = ei; x.ovf = eov; x.unf = eu;
        x.issue = cyc + 1; x.lmin = lmin; x.lmax = lmax;
        sb.push_back(x);
        drive(sgn, e, rm, qv, rv);
        @(negedge clk);
        ld_s = 1'b0;
        wait_done(nm);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish before 300000");
        $fatal(1);
    end

    initial begin
        int start;
        rst = 1'b1; ld_s = 1'b0; sign_s = 1'b0; exp_s = '0; rm_s = 3'd0; q_s = '0; r_s = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.o", o_o, 32'h0);
        chk("reset.flags", {29'd0, inexact_o, overflow_o, underflow_o}, 32'h0);
        chk("reset.busy", {31'd0, busy_o}, 32'h0);
        chk("reset.done", {31'd0, done_o}, 32'h0);

        //    name          sg exp  rm    q             r  expected     ix ov uf lat
        send("one",         0, 127, 3'd0, 27'h4000000, 0, 32'h3F800000, 0, 0, 0, 3, 3);
        send("normshift",   0, 128, 3'd0, 27'h2000000, 0, 32'h3F800000, 0, 0, 0, 3, 3);
        send("rne_tie_even",0, 127, 3'd0, 27'h4000004, 0, 32'h3F800000, 1, 0, 0, 3, 3);
        send("rne_tie_odd", 0, 127, 3'd0, 27'h400000C, 0, 32'h3F800002, 1, 0, 0, 3, 3);
        send("rup_sticky",  0, 127, 3'd3, 27'h4000001, 0, 32'h3F800001, 1, 0, 0, 3, 3);
        send("rne_carry",   0, 127, 3'd0, 27'h7FFFFFC, 0, 32'h40000000, 1, 0, 0, 3, 3);
        send("rmm_tie",     0, 127, 3'd4, 27'h4000004, 0, 32'h3F800001, 1, 0, 0, 3, 3);
        send("rtz_neg_rem", 1, 127, 3'd1, 27'h4000000, 1, 32'hBF800000, 1, 0, 0, 3, 3);
        send("rdn_neg_rem", 1, 127, 3'd2, 27'h4000000, 1, 32'hBF800001, 1, 0, 0, 3, 3);
        send("ovf_rne",     0, 255, 3'd0, 27'h4000000, 0, 32'h7F800000, 1, 1, 0, 3, 3);
        send("ovf_rtz",     0, 255, 3'd1, 27'h4000000, 0, 32'h7F7FFFFF, 1, 1, 0, 3, 3);
        send("ovf_rdn_pos", 0, 300, 3'd2, 27'h4000000, 0, 32'h7F7FFFFF, 1, 1, 0, 3, 3);
        send("neg_zero",    1, 50,  3'd0, 27'h0000000, 0, 32'h80000000, 0, 0, 0, 3, 3);
        send("denorm_exp0", 0, 0,   3'd0, 27'h4000000, 0, 32'h00400000, 0, 0, 0, 4, 4);
        send("denorm_m40",  0, -40, 3'd0, 27'h4000000, 0, 32'h00000000, 1, 0, 1, 4, 28);
        send("denorm_rup",  0, -40, 3'd3, 27'h4000000, 0, 32'h00000001, 1, 0, 1, 4, 28);

        // ld held high through busy and the done cycle: only one result appears.
        begin
            exp_t x;
            x.name = "ld_busy"; x.o = 32'h3F800000; x.inx = 0; x.ovf = 0; x.unf = 0;
            x.issue = cyc + 1; x.lmin = 3; x.lmax = 3;
            sb.push_back(x);
            start = done_cnt;
            drive(0, 127, 3'd0, 27'h4000000, 0);
            @(negedge clk);
            drive(1, 100, 3'd3, 27'h400000C, 1);
            wait_done("ld_busy");
            @(negedge clk);
            ld_s = 1'b0;
            repeat (8) @(negedge clk);
            chk("ld_busy.done_count", 32'(done_cnt - start), 32'd1);
        end

        // Synchronous reset while shifting a denormal: abort without done.
        start = done_cnt;
        drive(0, -40, 3'd3, 27'h4000000, 0);
        @(negedge clk);
        ld_s = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid.busy_before", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.busy", {31'd0, busy_o}, 32'h0);
        chk("rst_mid.o", o_o, 32'h0);
        chk("rst_mid.flags", {29'd0, inexact_o, overflow_o, underflow_o}, 32'h0);
        repeat (40) @(negedge clk);
        chk("rst_mid.no_done", 32'(done_cnt - start), 32'd0);

        send("after_rst",   0, 127, 3'd0, 27'h4000000, 0, 32'h3F800000, 0, 0, 0, 3, 3);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fpdivr8_normround.md
Name: fpdivr8_normround

Overview:
Post-divider normalise/round stage for the FP divide path. It consumes the raw mantissa quotient and remainder of the radix-8 divider, the pre-computed biased exponent and the sign, and produces a packed IEEE-754 binary result with exception flags. A small FSM handles normalisation, iterative denormal right-shift and rounding, with a one-cycle done pulse. NaN/Inf/zero operand special cases are bypassed upstream and never reach this block.

Parameters:
FPWID, 32, packed result width.
EMSB, 7, exponent MSB index (exponent width EMSB+1).
FMSB, 22, stored fraction MSB index.
QW, FMSB+5 (localparam, 27), quotient/remainder width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ld  in  1  start; pulse coincident with divider done
sign  in  1  result sign
exp  in  EMSB+3  signed biased exponent before normalisation (may be <=0 or >max)
rm  in  3  round mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
q  in  QW  quotient; q[QW-1] weight 2^0, q[QW-2] weight 2^-1, value in [0.5,2) or exactly 0
r  in  QW  divider remainder; only r!=0 is used
o  out  FPWID  packed result
inexact  out  1  result rounded
overflow  out  1  exponent overflow
underflow  out  1  tiny and inexact
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse, result valid

Behaviour:
- Reset: state IDLE; o=0; flags=0; busy=0; done=0.
- ld is sampled only in IDLE. A ld while busy is ignored; there is no queueing.
- On an accepted ld: register sign, exp, rm and q. Register sticky0 = (r!=0).
- States: IDLE -> NORM -> (DENORM)* -> ROUND -> IDLE.
- NORM:
  - If q[QW-1]=0: shift q left 1 and decrement exp.
  - If q==0: take the signed-zero path; go to ROUND with the zero flag set.
  - If exp<=0: go to DENORM. Otherwise go to ROUND.
- DENORM (one bit per cycle):
  - Shift the mantissa right 1, OR the shifted-out bit into sticky, increment exp.
  - Leave when exp==1; the encoded exponent field is then 0.
  - Cap: after FMSB+3 shifts the mantissa is all-sticky. Force the exit, with mantissa 0 and sticky = OR of everything.
- Mantissa layout after NORM: bit QW-1 is the integer bit; bits QW-2..3 are the fraction (FMSB+1 bits); bit 2 is guard (G); sticky S = q[1]|q[0]|sticky0.
- ROUND increment per mode:
  - RNE: G&(S|lsb).
  - RTZ: 0.
  - RDN: sign&(G|S).
  - RUP: ~sign&(G|S).
  - RMM: G.
  - inexact = G|S.
- Rounding carry-out: exp+1, mantissa becomes 1.0.
- A denormal that rounds up to 1.0 gives exponent field 1 (minimum normal).
- Overflow (exp >= 2^(EMSB+1)-1 after rounding):
  - overflow=1, inexact=1.
  - Result is Inf for RNE, RMM, RUP(+) and RDN(-); otherwise max finite.
- underflow = (took DENORM or exp==0) & inexact.
- Output update: o and flags register at the ROUND->IDLE edge. done pulses for exactly that one cycle. o and flags hold until the next done.
- Latency: ld at edge k gives done high after edge k+3, i.e. 3 cycles. A denormal adds n cycles, n <= FMSB+3.
- Back-to-back: ld in the same cycle as done is ignored (still busy). ld is accepted the following cycle.
- rst mid-operation: abort to IDLE; outputs cleared; no done.
- Width rule: exp arithmetic is signed EMSB+3 bits; no wrap is permitted within the specified input range.

Decomposition:
- Shared package fp_pkg holds:
  - round-mode constants RM_RNE..RM_RMM;
  - FPWID/EMSB/FMSB defaults;
  - state enum (IDLE, NORM, DENORM, ROUND).
- One sub-module, fpdiv_rnd: combinational. Takes mantissa, G, S, sign, rm; outputs the rounded mantissa, carry and inexact. It is reused by later FP stages.

Test Plan:
- q=27'h4000000, exp=127, r=0, RNE -> o=32'h3F800000, inexact=0; done exactly 3 cycles after ld.
- q=27'h2000000, exp=128 -> normalised, o=32'h3F800000.
- Rounding:
  - q=27'h4000004 RNE -> 32'h3F800000, inexact=1.
  - q=27'h400000C RNE -> 32'h3F800002.
  - q=27'h4000001 RUP -> 32'h3F800001.
  - q=27'h7FFFFFC exp=127 RNE -> 32'h40000000 (carry).
- q=27'h4000000, exp=255: RNE -> 32'h7F800000, overflow=1, inexact=1; RTZ -> 32'h7F7FFFFF.
- Denormal:
  - exp=0 -> o=32'h00400000, underflow=0, latency 4.
  - exp=-40 -> o=0, underflow=1, busy <= FMSB+3 extra cycles.
  - Same exp=-40 with RUP -> 32'h00000001.
- Handshake:
  - ld during busy -> ignored, single done.
  - rst asserted in DENORM -> IDLE next cycle, o=0, no done pulse.
